// File: rtl/run_det_pkg.sv
// Shared types for the run detector: run-state encoding and the run-width helper.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HIT
    } run_state_e;

    // Bits needed to hold a run length of 0..run_len inclusive.
    function automatic int run_w(input int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc && (q_q != {W{1'b1}}))
            q_d = q_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/run_detector.sv
// Detects runs of RUN_LEN consecutive qualified samples equal to tgt, with
// selectable overlapping mode and a saturating detection counter.
module run_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        i,
    input  logic                        tgt,
    input  logic                        ovl,
    input  logic                        clr,
    output logic                        y,
    output logic [run_w(RUN_LEN)-1:0]   run,
    output logic [CNT_W-1:0]            det_cnt
);

    localparam int RW = run_w(RUN_LEN);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

    logic [RW-1:0] run_q, run_d;
    logic          y_q, y_d;
    logic          tgt_q, tgt_d;
    logic          det;
    run_state_e    state;

    always_comb begin
        if (run_q == '0)          state = IDLE;
        else if (run_q == RUN_MAX) state = HIT;
        else                      state = COUNT;
    end

    always_comb begin
        run_d = run_q;
        tgt_d = tgt_q;
        det   = 1'b0;
        if (en) begin
            tgt_d = tgt;
            // A target switch restarts the run against the new target; the
            // current bit can at most begin a run, so it cannot detect.
            if (tgt != tgt_q) begin
                run_d = (i == tgt) ? RW'(1) : '0;
            end else if (i != tgt) begin
                run_d = '0;
            end else begin
                case (state)
                    HIT: begin
                        if (ovl) begin
                            run_d = RUN_MAX;
                            det   = 1'b1;
                        end else begin
                            run_d = RW'(1);
                        end
                    end
                    default: begin
                        run_d = run_q + RW'(1);
                        det   = (run_d == RUN_MAX);
                    end
                endcase
            end
        end
        y_d = det;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
            y_q   <= 1'b0;
            tgt_q <= tgt;
        end else begin
            run_q <= run_d;
            y_q   <= y_d;
            tgt_q <= tgt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (det),
        .q   (det_cnt)
    );

    assign y   = y_q;
    assign run = run_q;

endmodule
